// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM states, BCD constants and
// a digit-validity helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // True when the nibble encodes a legal decimal digit (0..9).
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with carry-in. Purely combinational; it is the only
// arithmetic in the serial adder.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    output logic [3:0] s_d,
    output logic       cout
);

    logic [4:0] t;
    logic [4:0] t_corr;

    // Binary sum, then decimal correction when the result exceeds 9.
    always_comb begin
        t      = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, cin};
        t_corr = t + {1'b0, BCD_CORR};
        if (t > {1'b0, BCD_MAX}) begin
            s_d  = t_corr[3:0];
            cout = 1'b1;
        end else begin
            s_d  = t[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: one digit per clock, LSD first, through
// a single bcd_digit_add instance. Start/busy/done handshake; sum and cout
// are held until the next accepted start.
// Optional feature: define BCD_CHECK_EN to flag non-BCD input nibbles on err.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int unsigned W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       dig_s;
    logic             dig_c;

    bcd_digit_add u_digit_add (
        .a_d  (a_sh_q[3:0]),
        .b_d  (b_sh_q[3:0]),
        .cin  (carry_q),
        .s_d  (dig_s),
        .cout (dig_c)
    );

    // Next-state logic for the FSM, datapath registers and registered outputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sum_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Result digits enter from the top so digit 0 lands in [3:0]
                // after DIGITS shifts.
                sum_d   = (sum_q >> 4) | (W'(dig_s) << (W - 4));
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = dig_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cout_d  = dig_c;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic bad_nibble;

    // Flag is evaluated only on an accepted start and held otherwise.
    always_comb begin
        bad_nibble = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a[4*i +: 4]) || !is_bcd_digit(b[4*i +: 4])) begin
                bad_nibble = 1'b1;
            end
        end
        err_d = err_q;
        if (state_q == IDLE && start) begin
            err_d = bad_nibble;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4): directed cases plus
// randomized valid-BCD operands checked against a decimal-integer model.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks   = 0;
    int failures = 0;

`ifdef BCD_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    bcd_serial_add_ctrl #(
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal value of a packed BCD word (valid digits only).
    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r + int'(v[4*i +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: add as decimal integers, carry is overflow past DIGITS digits.
    task automatic ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                           output logic [W-1:0] rs, output logic rc);
        int tot = bcd_to_int(ra) + bcd_to_int(rb);
        rc = (tot >= 10000);
        rs = int_to_bcd(tot % 10000);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // One operation: start sampled at the next edge (edge 0); cycle k is the
    // interval after edge k-1. Optionally pulses start in cycles 2 and 3.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_err, input bit pulse_start);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int c = 1; c <= DIGITS + 1; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            start = pulse_start && (c == 2 || c == 3);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done"}, 32'(done), 32'(c == DIGITS + 1));
            check({tag, " err"}, 32'(err), 32'(exp_err));
        end
        start = 1'b0;
        check({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(cout), 32'(exp_cout));
        @(posedge clk);
        #1;
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " held sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " held err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic ref_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input bit pulse_start);
        logic [W-1:0] es;
        logic         ec;
        ref_add(ta, tb_, es, ec);
        do_op(tag, ta, tb_, es, ec, 1'b0, pulse_start);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        ref_op("8+9", 16'h0008, 16'h0009, 1'b0);
        ref_op("ripple", 16'h9999, 16'h0001, 1'b0);
        ref_op("4567+5678", 16'h4567, 16'h5678, 1'b0);
        ref_op("zero", 16'h0000, 16'h0000, 1'b0);
        ref_op("ignored start", 16'h0123, 16'h0456, 1'b1);

        // Reset in cycle 2 of an operation aborts it.
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort no done", 32'(done), 32'd0);
            check("abort stay idle", 32'(busy), 32'd0);
        end
        ref_op("after abort", 16'h1234, 16'h1111, 1'b0);

        // Invalid nibble: digit 0 is 10+1 -> 1 with carry, digit 1 is 0+0+1.
        do_op("bad nibble", 16'h000A, 16'h0001, 16'h0011, 1'b0, ERR_ON, 1'b0);
        ref_op("err cleared", 16'h0005, 16'h0004, 1'b0);

        for (int n = 0; n < 25; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            ref_op($sformatf("rand%0d", n), ra, rb, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
